// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Purpose  : EX/MEM -> MEM/WB bus bundle for the MEM-stage access unit.
//            master = pipeline side, slave = mem_access_unit.
// Revision : 1.0  initial release
// ============================================================================
interface mem_access_unit_if;
    // EX/MEM side
    logic [31:0] Address;
    logic [31:0] Write_Data;
    logic [4:0]  regdst;
    logic        RegWrite_i;
    logic        Mem_Read;
    logic        Mem_Write;
    logic        MemtoReg_i;
    // Pipeline hold and MEM/WB side
    logic        stall;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  regdst_o;
    logic        RegWrite_o;
    logic        MemtoReg_o;
    logic        misalign;

    modport master (
        output Address, Write_Data, regdst, RegWrite_i, Mem_Read, Mem_Write, MemtoReg_i,
        input  stall, read_data, alu_result, regdst_o, RegWrite_o, MemtoReg_o, misalign
    );

    modport slave (
        input  Address, Write_Data, regdst, RegWrite_i, Mem_Read, Mem_Write, MemtoReg_i,
        output stall, read_data, alu_result, regdst_o, RegWrite_o, MemtoReg_o, misalign
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage load/store responder with a word-addressed data memory
//            and fixed access latency. Freezes upstream with a combinational
//            stall while an access is in flight and injects writeback bubbles.
// Revision : 1.0  initial release
// ============================================================================
module mem_access_unit #(
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int LATENCY = 2
) (
    input  wire                  clk,
    input  wire                  rst,
    mem_access_unit_if.slave     bus
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_BUSY     = 1'b1;
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    // Data memory: never reset, contents survive rst
    logic [31:0] mem [DEPTH];

    // Control state
    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Holding registers for the access in flight
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic        m2r_q, m2r_d;
    logic        is_store_q, is_store_d;
    logic        misal_q, misal_d;

    // MEM/WB output registers
    logic [31:0] read_data_q, read_data_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [4:0]  regdst_o_q, regdst_o_d;
    logic        regwrite_o_q, regwrite_o_d;
    logic        memtoreg_o_q, memtoreg_o_d;
    logic        misalign_q, misalign_d;

    // Memory write port controls
    logic          w_mem_we;
    logic [AW-1:0] w_mem_idx;
    logic          w_req;
    logic          w_stall;

    assign w_req     = bus.Mem_Read | bus.Mem_Write;
    assign w_mem_idx = addr_q[AW+1:2];

    // Next-state, stall and MEM/WB capture logic; default output is a bubble
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        rw_d         = rw_q;
        m2r_d        = m2r_q;
        is_store_d   = is_store_q;
        misal_d      = misal_q;
        read_data_d  = 32'd0;
        alu_result_d = 32'd0;
        regdst_o_d   = 5'd0;
        regwrite_o_d = 1'b0;
        memtoreg_o_d = 1'b0;
        misalign_d   = 1'b0;
        w_mem_we     = 1'b0;
        w_stall      = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (w_req) begin
                    w_stall    = 1'b1;
                    addr_d     = bus.Address;
                    wdata_d    = bus.Write_Data;
                    rd_d       = bus.regdst;
                    rw_d       = bus.RegWrite_i;
                    m2r_d      = bus.MemtoReg_i;
                    // Read+write together behaves as a store
                    is_store_d = bus.Mem_Write;
                    misal_d    = (bus.Address[1:0] != 2'b00);
                    cnt_d      = c_CNT_INIT;
                    state_d    = c_BUSY;
                end else begin
                    alu_result_d = bus.Address;
                    regdst_o_d   = bus.regdst;
                    regwrite_o_d = bus.RegWrite_i;
                    memtoreg_o_d = bus.MemtoReg_i;
                end
            end
            default: begin
                if (cnt_q != 4'd0) begin
                    w_stall = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    // Completion edge: upstream is released this cycle
                    alu_result_d = addr_q;
                    regdst_o_d   = rd_q;
                    memtoreg_o_d = m2r_q;
                    if (misal_q) begin
                        misalign_d   = 1'b1;
                        regwrite_o_d = 1'b0;
                    end else begin
                        regwrite_o_d = rw_q;
                        if (is_store_q) begin
                            w_mem_we = 1'b1;
                        end else begin
                            read_data_d = mem[w_mem_idx];
                        end
                    end
                    state_d = c_IDLE;
                end
            end
        endcase
    end

    // State, holding and MEM/WB registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= c_IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            rd_q         <= 5'd0;
            rw_q         <= 1'b0;
            m2r_q        <= 1'b0;
            is_store_q   <= 1'b0;
            misal_q      <= 1'b0;
            read_data_q  <= 32'd0;
            alu_result_q <= 32'd0;
            regdst_o_q   <= 5'd0;
            regwrite_o_q <= 1'b0;
            memtoreg_o_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            rw_q         <= rw_d;
            m2r_q        <= m2r_d;
            is_store_q   <= is_store_d;
            misal_q      <= misal_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            regdst_o_q   <= regdst_o_d;
            regwrite_o_q <= regwrite_o_d;
            memtoreg_o_q <= memtoreg_o_d;
            misalign_q   <= misalign_d;
        end
    end

    // Store write port; a reset in the completion cycle cancels the write
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            mem[w_mem_idx] <= wdata_q;
        end
    end

    assign bus.stall      = w_stall;
    assign bus.read_data  = read_data_q;
    assign bus.alu_result = alu_result_q;
    assign bus.regdst_o   = regdst_o_q;
    assign bus.RegWrite_o = regwrite_o_q;
    assign bus.MemtoReg_o = memtoreg_o_q;
    assign bus.misalign   = misalign_q;

endmodule
`default_nettype wire
